// File: rtl/sseg_counter.sv
// sseg_counter
// Decimal event counter that counts increment strobes in packed BCD and keeps a
// sticky overflow flag that sets when the count wraps from all nines to zero.
// It also scans the count onto a multiplexed common-anode seven-segment display.
//
// Ports:
//   clk        - system clock, all state on its rising edge
//   reset_n    - asynchronous active-low reset
//   inc        - increment strobe, one count per high cycle
//   clr        - synchronous clear of count and counter_of
//   load       - synchronous load of load_val (nibbles > 9 load as 0)
//   load_val   - packed BCD load value, digit 0 in [3:0]
//   of_clr     - clears counter_of only (a same-cycle wrap wins)
//   count      - registered packed BCD count
//   counter_of - registered sticky overflow flag
//   sseg       - registered active-low segments {dp,g,f,e,d,c,b,a}
//   an         - registered active-low digit enables, one-hot-low
module sseg_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  of_clr,
    output logic [4*DIGITS-1:0]   count,
    output logic                  counter_of,
    output logic [7:0]            sseg,
    output logic [DIGITS-1:0]     an
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Segment pattern (active low, {g..a}) for one BCD digit; non-BCD is blank.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Replace any non-BCD nibble with zero so the count always holds legal BCD.
    function automatic logic [4*DIGITS-1:0] bcd_sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Ripple BCD increment: a digit moves only while every lower digit is 9.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!carry) begin
                r[4*i +: 4] = v[4*i +: 4];
            end else if (v[4*i +: 4] == 4'd9) begin
                r[4*i +: 4] = 4'd0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                carry       = 1'b0;
            end
        end
        return r;
    endfunction

    // True when every digit of v is 9, i.e. the next increment wraps.
    function automatic logic bcd_all_nines(input logic [4*DIGITS-1:0] v);
        logic all9;
        all9 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                all9 = 1'b0;
            end
        end
        return all9;
    endfunction

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                of_q, of_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          sseg_q, sseg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                wrap_s;
    logic [3:0]          cur_nib_s;

    // A wrap only happens when the increment is the winning update.
    assign wrap_s = inc & ~clr & ~load & bcd_all_nines(count_q);

    // Count and overflow next state; clr beats load beats inc, a wrap beats of_clr.
    always_comb begin
        count_d = count_q;
        of_d    = of_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = bcd_sanitize(load_val);
        end else if (inc) begin
            count_d = bcd_inc(count_q);
        end else begin
            count_d = count_q;
        end

        if (clr) begin
            of_d = 1'b0;
        end else if (wrap_s) begin
            of_d = 1'b1;
        end else if (of_clr) begin
            of_d = 1'b0;
        end else begin
            of_d = of_q;
        end
    end

    // Scan prescaler and digit index, free-running and independent of the count.
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end
    end

    // Display drive from the current index and count; registered below so an and
    // sseg always change on the same edge.
    always_comb begin
        cur_nib_s = 4'd0;
        an_d      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib_s = count_q[4*i +: 4];
                an_d[i]   = 1'b0;
            end else begin
                an_d[i]   = 1'b1;
            end
        end
        sseg_d = {1'b1, glyph(cur_nib_s)};
    end

    // State registers; reset leaves the display dark and the scan at digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            of_q    <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            sseg_q  <= 8'hFF;
            an_q    <= '1;
        end else begin
            count_q <= count_d;
            of_q    <= of_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            sseg_q  <= sseg_d;
            an_q    <= an_d;
        end
    end

    assign count      = count_q;
    assign counter_of = of_q;
    assign sseg       = sseg_q;
    assign an         = an_q;

endmodule

// File: tb/tb_sseg_counter.sv
module tb_sseg_counter;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        reset_n;
    logic        inc;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        of_clr;
    logic [15:0] count;
    logic        counter_of;
    logic [7:0]  sseg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;

    sseg_counter #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (inc),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .of_clr     (of_clr),
        .count      (count),
        .counter_of (counter_of),
        .sseg       (sseg),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        inc;
        logic        clr;
        logic        load;
        logic        of_clr;
        logic [15:0] load_val;
        logic [15:0] exp_count;
        logic        exp_of;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic i, input logic c, input logic l,
                         input logic oc, input logic [15:0] lv);
        inc = i; clr = c; load = l; of_clr = oc; load_val = lv;
    endtask

    // One clocked cycle with the given inputs, then idle inputs, sampled #1 after the edge.
    task automatic step(input logic i, input logic c, input logic l,
                        input logic oc, input logic [15:0] lv);
        drive(i, c, l, oc, lv);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Wait (bounded) for the first edge on which an shows the given pattern.
    task automatic wait_an(input logic [3:0] target, input string name);
        int k;
        k = 0;
        while (an === target && k < 40) begin
            @(posedge clk); #1; k++;
        end
        while (an !== target && k < 40) begin
            @(posedge clk); #1; k++;
        end
        if (an !== target) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout waiting for an=0x%0h, got 0x%0h", name, target, an);
        end
    endtask

    initial begin
        // {name, inc, clr, load, of_clr, load_val, exp_count, exp_of}
        vecs[0]  = '{"load_0199",       1'b0, 1'b0, 1'b1, 1'b0, 16'h0199, 16'h0199, 1'b0};
        vecs[1]  = '{"bcd_carry",       1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0200, 1'b0};
        vecs[2]  = '{"idle_hold",       1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0200, 1'b0};
        vecs[3]  = '{"load_9998",       1'b0, 1'b0, 1'b1, 1'b0, 16'h9998, 16'h9998, 1'b0};
        vecs[4]  = '{"inc_to_9999",     1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0};
        vecs[5]  = '{"wrap",            1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{"after_wrap",      1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1};
        vecs[7]  = '{"of_sticky",       1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1};
        vecs[8]  = '{"of_clr",          1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0};
        vecs[9]  = '{"load_9999",       1'b0, 1'b0, 1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0};
        vecs[10] = '{"wrap_vs_of_clr",  1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{"clr_load_inc",    1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0};
        vecs[12] = '{"invalid_load",    1'b0, 1'b0, 1'b1, 1'b0, 16'h3AF7, 16'h3007, 1'b0};
        vecs[13] = '{"load_beats_inc",  1'b1, 1'b0, 1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0};
        vecs[14] = '{"wrap_again",      1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[15] = '{"load_keeps_of",   1'b0, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0042, 1'b1};
        vecs[16] = '{"clr_clears_of",   1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'h0);
        check("rst_of",    32'(counter_of), 32'h0);
        check("rst_an",    32'(an), 32'hF);
        check("rst_sseg",  32'(sseg), 32'hFF);

        // Release reset away from the edge; scan starts on the next rising edge.
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] exp_an;
            @(posedge clk); #1;
            exp_an = ~(4'b0001 << ((k / SCAN_DIV) % DIGITS));
            check($sformatf("scan_an_%0d", k), 32'(an), 32'(exp_an));
            // glyph 0x40 for digit 0 with the decimal point off
            check($sformatf("scan_sseg_%0d", k), 32'(sseg), 32'hC0);
            check($sformatf("scan_count_%0d", k), 32'(count), 32'h0);
            check($sformatf("scan_of_%0d", k), 32'(counter_of), 32'h0);
        end

        // Table-driven count / flag vectors.
        for (int v = 0; v < 17; v++) begin
            step(vecs[v].inc, vecs[v].clr, vecs[v].load, vecs[v].of_clr, vecs[v].load_val);
            check({vecs[v].name, "_count"}, 32'(count), 32'(vecs[v].exp_count));
            check({vecs[v].name, "_of"},    32'(counter_of), 32'(vecs[v].exp_of));
        end

        // Glyph for the carried hundreds digit of 0x0200.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0199);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        wait_an(4'b1011, "wait_0200_d2");
        check("glyph_0200_d2", 32'(sseg), 32'hA4);
        wait_an(4'b1110, "wait_0200_d0");
        check("glyph_0200_d0", 32'(sseg), 32'hC0);

        // Invalid load 0x3AF7 shows as 3,0,0,7.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h3AF7);
        @(posedge clk); #1;
        wait_an(4'b1101, "wait_3007_d1");
        check("glyph_3007_d1", 32'(sseg), 32'hC0);
        wait_an(4'b0111, "wait_3007_d3");
        check("glyph_3007_d3", 32'(sseg), 32'hB0);
        wait_an(4'b1110, "wait_3007_d0");
        check("glyph_3007_d0", 32'(sseg), 32'hF8);

        // Reset mid-operation: count 0x0042, flag set, scan on digit 2.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h9999);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0042);
        check("pre_rst_count", 32'(count), 32'h0042);
        check("pre_rst_of",    32'(counter_of), 32'h1);
        wait_an(4'b1011, "wait_idx2");
        check("pre_rst_sseg",  32'(sseg), 32'hC0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'h0);
        check("async_rst_of",    32'(counter_of), 32'h0);
        check("async_rst_an",    32'(an), 32'hF);
        check("async_rst_sseg",  32'(sseg), 32'hFF);
        #4;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [3:0] exp_an;
            @(posedge clk); #1;
            exp_an = (k < SCAN_DIV) ? 4'b1110 : 4'b1101;
            check($sformatf("restart_an_%0d", k), 32'(an), 32'(exp_an));
            check($sformatf("restart_sseg_%0d", k), 32'(sseg), 32'hC0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
